// File: rtl/common_pkg.sv
// common_pkg: shared spin-array sizing and mask_to_index FSM states.
package common_pkg;
  localparam int NUM_SPINS = 64;
  localparam int M2I_IDX_W = $clog2(NUM_SPINS);
  localparam int M2I_CNT_W = $clog2(NUM_SPINS + 1);
  typedef enum logic {M2I_IDLE, M2I_EMIT} m2i_state_t;
endpackage

// File: rtl/lowest_set_finder.sv
// lowest_set_finder: index and one-hot of the lowest set bit of vec.
module lowest_set_finder #(
  parameter int NUM_SPINS = 64,
  parameter int IDX_W = $clog2(NUM_SPINS)
) (
  input  logic [NUM_SPINS-1:0] vec,
  output logic                 found,
  output logic [IDX_W-1:0]     idx,
  output logic [NUM_SPINS-1:0] onehot
);
  assign found  = |vec;
  assign onehot = vec & (~vec + NUM_SPINS'(1));
  always_comb begin
    idx = '0;
    for (int i = NUM_SPINS - 1; i >= 0; i--) if (vec[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/mask_to_index.sv
// mask_to_index: streams ascending set-bit indices of a mask, LANES per beat, plus its popcount.
module mask_to_index
  import common_pkg::*;
#(
  parameter int NUM_SPINS = common_pkg::NUM_SPINS,
  parameter int LANES = 2,
  localparam int IDX_W = $clog2(NUM_SPINS),
  localparam int CNT_W = $clog2(NUM_SPINS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mask_valid,
  output logic                   mask_ready,
  input  logic [NUM_SPINS-1:0]   mask,
  output logic                   idx_valid,
  input  logic                   idx_ready,
  output logic [LANES*IDX_W-1:0] idx_data,
  output logic [LANES-1:0]       idx_lane_vld,
  output logic                   idx_last,
  output logic [CNT_W-1:0]       num_ones,
  output logic                   num_ones_valid,
  output logic                   busy
);
  m2i_state_t state, state_nxt;
  logic [NUM_SPINS-1:0] rem, rem_nxt;
  logic [NUM_SPINS-1:0] vec [LANES+1];
  logic fire, accept;
  assign vec[0] = rem;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic found;
    logic [IDX_W-1:0] idx;
    logic [NUM_SPINS-1:0] onehot;
    lowest_set_finder #(.NUM_SPINS(NUM_SPINS), .IDX_W(IDX_W)) u_lsf (
      .vec(vec[k]), .found(found), .idx(idx), .onehot(onehot)
    );
    assign vec[k+1] = vec[k] & ~onehot;
    assign idx_lane_vld[k] = busy & found;
    assign idx_data[k*IDX_W +: IDX_W] = idx_lane_vld[k] ? idx : '0;
  end
  assign busy       = state == M2I_EMIT;
  assign idx_valid  = busy;
  // Nothing left after the lanes take their bits means this beat is the last.
  assign idx_last   = busy & ~|vec[LANES];
  assign fire       = idx_valid & idx_ready;
  assign mask_ready = reset & (state == M2I_IDLE | (fire & idx_last));
  assign accept     = mask_valid & mask_ready;
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (fire) begin
      rem_nxt   = vec[LANES];
      state_nxt = idx_last ? M2I_IDLE : M2I_EMIT;
    end
    if (accept) begin
      rem_nxt   = mask;
      state_nxt = M2I_EMIT;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= M2I_IDLE;
      rem            <= '0;
      num_ones       <= '0;
      num_ones_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (accept) begin
        num_ones       <= CNT_W'($countones(mask));
        num_ones_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mask_to_index.sv
// tb_mask_to_index: randomized and directed checks against a beat-queue reference model.
module tb_mask_to_index;
  localparam int N = 16, L = 2, IW = 4, CW = 5;
  typedef struct packed {
    logic [L*IW-1:0] data;
    logic [L-1:0]    vld;
    logic            last;
  } beat_t;
  logic clk = 0, reset = 0, mask_valid = 0, idx_ready = 0;
  logic [N-1:0] mask = '0;
  logic mask_ready, idx_valid, idx_last, num_ones_valid, busy;
  logic [L*IW-1:0] idx_data;
  logic [L-1:0] idx_lane_vld;
  logic [CW-1:0] num_ones;
  beat_t q[$];
  int total = 0, bad = 0, m_ones = 0;
  logic m_ones_v = 0;

  mask_to_index #(.NUM_SPINS(N), .LANES(L)) dut (
    .clk(clk), .reset(reset), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask(mask), .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
    .idx_lane_vld(idx_lane_vld), .idx_last(idx_last), .num_ones(num_ones),
    .num_ones_valid(num_ones_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_mask(input logic [N-1:0] m);
    int ix[$];
    beat_t t;
    for (int i = 0; i < N; i++) if (m[i]) ix.push_back(i);
    if (ix.size() == 0) begin
      t = '0;
      t.last = 1'b1;
      q.push_back(t);
    end
    for (int b = 0; b < ix.size(); b += L) begin
      t = '0;
      for (int k = 0; k < L; k++)
        if (b + k < ix.size()) begin
          t.data[k*IW +: IW] = IW'(ix[b+k]);
          t.vld[k] = 1'b1;
        end
      t.last = (b + L >= ix.size());
      q.push_back(t);
    end
  endtask

  task automatic cycle(input logic mv, input logic [N-1:0] m, input logic rdy);
    logic ev, fire, er;
    beat_t e;
    @(negedge clk);
    mask_valid = mv;
    mask = m;
    idx_ready = rdy;
    #1;
    ev = q.size() != 0;
    e = ev ? q[0] : '0;
    chk("idx_valid", 32'(idx_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(ev));
    chk("idx_data", 32'(idx_data), 32'(e.data));
    chk("lane_vld", 32'(idx_lane_vld), 32'(e.vld));
    chk("idx_last", 32'(idx_last), 32'(e.last));
    fire = ev && rdy;
    er = (q.size() == 0) || (fire && e.last);
    chk("mask_ready", 32'(mask_ready), 32'(er));
    chk("num_ones", 32'(num_ones), 32'(m_ones));
    chk("ones_valid", 32'(num_ones_valid), 32'(m_ones_v));
    if (fire) void'(q.pop_front());
    if (mv && er) begin
      push_mask(m);
      m_ones = $countones(m);
      m_ones_v = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(0, '0, 1);
    chk("drained", 32'(q.size()), 0);
    cycle(0, '0, 1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    reset = 0;
    mask_valid = 1;
    #1;
    q.delete();
    m_ones = 0;
    m_ones_v = 0;
    chk("rst_idx_valid", 32'(idx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ones_valid", 32'(num_ones_valid), 0);
    chk("rst_num_ones", 32'(num_ones), 0);
    chk("rst_mask_ready", 32'(mask_ready), 0);
    chk("rst_lane_vld", 32'(idx_lane_vld), 0);
    chk("rst_last", 32'(idx_last), 0);
    chk("rst_data", 32'(idx_data), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    mask_valid = 0;
  endtask

  initial begin
    logic [N-1:0] m;
    rst_pulse();
    cycle(1, 16'h8421, 1); drain();
    cycle(1, 16'h0007, 1); drain();
    cycle(1, 16'h0000, 1); drain();
    cycle(1, 16'hFFFF, 1); cycle(0, '0, 1);
    repeat (3) cycle(0, '0, 0);
    drain();
    cycle(1, 16'h0003, 1); cycle(1, 16'h0100, 1); drain();
    cycle(1, 16'hFFFF, 1); cycle(0, '0, 1); cycle(0, '0, 1);
    rst_pulse();
    cycle(1, 16'h0010, 1); drain();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 4)
        0: m = N'($urandom);
        1: m = N'($urandom & $urandom & $urandom);
        2: m = '0;
        default: m = N'($urandom | $urandom);
      endcase
      if ($urandom % 500 == 0) rst_pulse();
      else cycle(($urandom % 3) != 0, m, ($urandom % 4) != 0);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
